// File: rtl/regfile_pkg.sv
// Shared defaults and types for the scoreboarded register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NUM_RD_MAX = 4;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
    typedef logic [DATA_W_DEF-1:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy tracking for in-flight producers, plus registered busy count.
// Latency: issue/writeback change busy_o and busy_cnt_o one edge after they are sampled.
// Backpressure: none; every issue and writeback is accepted, issue wins on a same-address collision.
//
// Ports:
//   clk_i, rst_n_i          clock, async active-low reset
//   iss_en_i, iss_addr_i    destination of an issuing instruction (sets busy)
//   wb_en_i, wb_addr_i      writeback destination (clears busy)
//   busy_o                  one busy bit per register, bit 0 always 0
//   busy_cnt_o              popcount of busy_o
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  iss_en_i,
    input  logic [ADDR_W-1:0]     iss_addr_i,
    input  logic                  wb_en_i,
    input  logic [ADDR_W-1:0]     wb_addr_i,
    output logic [2**ADDR_W-1:0]  busy_o,
    output logic [ADDR_W:0]       busy_cnt_o
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_nxt;
    logic [ADDR_W:0]  cnt_q;
    logic [ADDR_W:0]  cnt_nxt;

    // Writeback clears first, then issue sets, so a same-cycle issue to the
    // same register leaves it busy for the new producer.
    always_comb begin
        busy_nxt = busy_q;
        if (wb_en_i && (wb_addr_i != '0)) begin
            busy_nxt[wb_addr_i] = 1'b0;
        end
        if (iss_en_i && (iss_addr_i != '0)) begin
            busy_nxt[iss_addr_i] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // Counting the next-state vector keeps the count registered yet exactly
    // aligned with busy_q.
    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[i]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_nxt;
            cnt_q  <= cnt_nxt;
        end
    end

    assign busy_o     = busy_q;
    assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with writeback port, r0 hardwired to zero and RAW scoreboard.
// Latency: reads are combinational (0 cycles); writes visible next cycle, or same cycle with bypass.
// Backpressure: none internally; stall_o asks the pipeline to hold while a read source is busy.
//
// Ports:
//   clk_i, rst_n_i                  clock, async active-low reset
//   rd_addr_i / rd_data_o / rd_busy_o   NUM_RD read ports, port k packed at [k*W +: W]
//   iss_en_i, iss_addr_i            instruction issue with destination register
//   wb_en_i, wb_addr_i, wb_data_i   writeback port
//   stall_o                         OR of rd_busy_o
//   busy_cnt_o                      number of busy registers
// Build option: define REGFILE_SB_BYPASS_EN to forward a same-cycle writeback
// to matching read ports and mask their busy flag.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        rd_busy_o,
    input  logic                     iss_en_i,
    input  logic [ADDR_W-1:0]        iss_addr_i,
    input  logic                     wb_en_i,
    input  logic [ADDR_W-1:0]        wb_addr_i,
    input  logic [DATA_W-1:0]        wb_data_i,
    output logic                     stall_o,
    output logic [ADDR_W:0]          busy_cnt_o
);

    localparam int DEPTH = 2**ADDR_W;

    if ((NUM_RD < 1) || (NUM_RD > NUM_RD_MAX)) begin : g_bad_num_rd
        $error("regfile_sb: NUM_RD must be in 1..4");
    end

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  busy;

    regfile_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .iss_en_i   (iss_en_i),
        .iss_addr_i (iss_addr_i),
        .wb_en_i    (wb_en_i),
        .wb_addr_i  (wb_addr_i),
        .busy_o     (busy),
        .busy_cnt_o (busy_cnt_o)
    );

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wb_en_i && (wb_addr_i != '0)) begin
            mem_q[wb_addr_i] <= wb_data_i;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              hit;

        assign addr = rd_addr_i[k*ADDR_W +: ADDR_W];

`ifdef REGFILE_SB_BYPASS_EN
        // Gated by reset so the forwarding path cannot leak wb_data_i while
        // the array is held clear.
        assign hit = rst_n_i && wb_en_i && (wb_addr_i == addr) && (addr != '0);
`else
        assign hit = 1'b0;
`endif

        always_comb begin
            rd_data_o[k*DATA_W +: DATA_W] = '0;
            rd_busy_o[k]                  = 1'b0;
            if (rst_n_i && (addr != '0)) begin
                if (hit) begin
                    rd_data_o[k*DATA_W +: DATA_W] = wb_data_i;
                end else begin
                    rd_data_o[k*DATA_W +: DATA_W] = mem_q[addr];
                    rd_busy_o[k]                  = busy[addr];
                end
            end
        end
    end

    assign stall_o = |rd_busy_o;

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

`ifdef REGFILE_SB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;

    // default-parameter instance
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        stall;
    logic [5:0]  busy_cnt;

    // wide instance: 4 read ports, 64-bit data
    logic [19:0]  rd_addr4;
    logic [255:0] rd_data4;
    logic [3:0]   rd_busy4;
    logic         iss_en4;
    logic [4:0]   iss_addr4;
    logic         wb_en4;
    logic [4:0]   wb_addr4;
    logic [63:0]  wb_data4;
    logic         stall4;
    logic [5:0]   busy_cnt4;

    int errors = 0;
    int checks = 0;

    // reference model: architectural contents and outstanding producers
    logic [31:0] m_mem  [32];
    bit          m_busy [32];

    always #5 clk_i = ~clk_i;

    regfile_sb u_dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (rd_data),
        .rd_busy_o  (rd_busy),
        .iss_en_i   (iss_en),
        .iss_addr_i (iss_addr),
        .wb_en_i    (wb_en),
        .wb_addr_i  (wb_addr),
        .wb_data_i  (wb_data),
        .stall_o    (stall),
        .busy_cnt_o (busy_cnt)
    );

    regfile_sb #(.DATA_W(64), .ADDR_W(5), .NUM_RD(4)) u_dut4 (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .rd_addr_i  (rd_addr4),
        .rd_data_o  (rd_data4),
        .rd_busy_o  (rd_busy4),
        .iss_en_i   (iss_en4),
        .iss_addr_i (iss_addr4),
        .wb_en_i    (wb_en4),
        .wb_addr_i  (wb_addr4),
        .wb_data_i  (wb_data4),
        .stall_o    (stall4),
        .busy_cnt_o (busy_cnt4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    // Compare every combinational output of the narrow instance against the model.
    task automatic check_reads(input string tag);
        logic [4:0]  a;
        logic [31:0] ed;
        logic        eb;
        logic        es;
        es = 1'b0;
        for (int k = 0; k < 2; k++) begin
            a = rd_addr[k*5 +: 5];
            if (a == 5'd0) begin
                ed = '0;
                eb = 1'b0;
            end else if (BYP && wb_en && (wb_addr == a)) begin
                ed = wb_data;
                eb = 1'b0;
            end else begin
                ed = m_mem[a];
                eb = m_busy[a];
            end
            es |= eb;
            chk($sformatf("%s_data%0d", tag, k), {32'h0, rd_data[k*32 +: 32]}, {32'h0, ed});
            chk($sformatf("%s_busy%0d", tag, k), {63'h0, rd_busy[k]}, {63'h0, eb});
        end
        chk($sformatf("%s_stall", tag), {63'h0, stall}, {63'h0, es});
        chk($sformatf("%s_cnt", tag), {58'h0, busy_cnt}, 64'(model_count()));
    endtask

    task automatic drive(input logic ie, input logic [4:0] ia,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] r0, input logic [4:0] r1);
        iss_en   = ie;
        iss_addr = ia;
        wb_en    = we;
        wb_addr  = wa;
        wb_data  = wd;
        rd_addr  = {r1, r0};
    endtask

    // One clock: check outputs mid-cycle, then advance the model at the edge.
    task automatic cycle(input string tag);
        @(negedge clk_i);
        check_reads(tag);
        @(posedge clk_i);
        if (wb_en && (wb_addr != 5'd0)) begin
            m_mem[wb_addr]  = wb_data;
            m_busy[wb_addr] = 1'b0;
        end
        if (iss_en && (iss_addr != 5'd0)) m_busy[iss_addr] = 1'b1;
        #1;
    endtask

    task automatic rand_cycle();
        logic [4:0] wa;
        wa = 5'($urandom_range(0, 31));
        drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
              1'($urandom_range(0, 1)), wa, $urandom,
              ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)),
              5'($urandom_range(0, 31)));
        cycle("rnd");
    endtask

    initial begin
        model_clear();
        drive(1'b1, 5'd5, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5);
        iss_en4  = 1'b0; iss_addr4 = '0;
        wb_en4   = 1'b0; wb_addr4  = '0; wb_data4 = '0;
        rd_addr4 = '0;

        // reset held: outputs must be quiet even with a matching writeback present
        #3;
        for (int i = 0; i < 32; i += 4) begin
            rd_addr = {5'(31 - i), 5'(i)};
            #1;
            chk("rst_data", rd_data, 64'h0);
            chk("rst_busy", {62'h0, rd_busy}, 64'h0);
            chk("rst_stall", {63'h0, stall}, 64'h0);
            chk("rst_cnt", {58'h0, busy_cnt}, 64'h0);
        end
        @(posedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        drive(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd31);
        cycle("idle");

        // issue r5, writeback two cycles later, reading r5 throughout
        drive(1'b1, 5'd5, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        cycle("raw_iss");
        drive(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        cycle("raw_wait");
        drive(1'b0, 5'd0, 1'b1, 5'd5, 32'h1234_5678, 5'd5, 5'd5);
        cycle("raw_wb");
        drive(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
        cycle("raw_done");

        // same-cycle issue and writeback to r7: issue wins, data still lands
        drive(1'b1, 5'd7, 1'b1, 5'd7, 32'h0000_00A5, 5'd7, 5'd5);
        cycle("col");
        drive(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
        cycle("col_after");

        // r0: writes and issues are dropped
        drive(1'b1, 5'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        cycle("r0_req");
        drive(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd7);
        cycle("r0_after");

        // writeback to a non-busy register
        drive(1'b0, 5'd0, 1'b1, 5'd9, 32'hCAFE_F00D, 5'd9, 5'd9);
        cycle("wb_idle");

        for (int n = 0; n < 300; n++) rand_cycle();

        // fill the scoreboard r1..r31
        for (int r = 1; r < 32; r++) begin
            drive(1'b1, 5'(r), 1'b0, 5'd0, 32'h0, 5'(r), 5'($urandom_range(0, 31)));
            cycle("fill");
        end
        drive(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd31);
        cycle("full");
        chk("full_cnt_is_31", {58'h0, busy_cnt}, 64'd31);

        // reset in mid-cycle while issuing and writing back
        drive(1'b1, 5'd4, 1'b1, 5'd3, 32'h5555_AAAA, 5'd3, 5'd4);
        @(posedge clk_i);
        #2;
        rst_n_i = 1'b0;
        #1;
        chk("arst_cnt", {58'h0, busy_cnt}, 64'h0);
        chk("arst_stall", {63'h0, stall}, 64'h0);
        chk("arst_busy", {62'h0, rd_busy}, 64'h0);
        chk("arst_data", rd_data, 64'h0);
        model_clear();
        @(negedge clk_i);
        rst_n_i = 1'b1;
        drive(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd5);
        cycle("post_rst");
        for (int n = 0; n < 100; n++) rand_cycle();

        // wide instance: r3 busy, r9 written, read r3,r3,r9,r0
        drive(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        iss_en4  = 1'b1; iss_addr4 = 5'd3;
        wb_en4   = 1'b1; wb_addr4  = 5'd9; wb_data4 = 64'hDEAD_BEEF_0123_4567;
        @(posedge clk_i);
        #1;
        iss_en4  = 1'b0;
        wb_en4   = 1'b0;
        rd_addr4 = {5'd0, 5'd9, 5'd3, 5'd3};
        @(negedge clk_i);
        chk("w4_busy", {60'h0, rd_busy4}, 64'h3);
        chk("w4_stall", {63'h0, stall4}, 64'h1);
        chk("w4_cnt", {58'h0, busy_cnt4}, 64'h1);
        chk("w4_data_r3", rd_data4[63:0], 64'h0);
        chk("w4_data_r9", rd_data4[191:128], 64'hDEAD_BEEF_0123_4567);
        chk("w4_data_r0", rd_data4[255:192], 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
